// File: rtl/pio_ctrl_regs.sv
// PIO control/status register block: CTRL, FIFO status/debug, IRQ and interrupt
// enable/force/status registers with XOR/SET/CLR address aliases and registered reads.
module pio_ctrl_regs #(
    parameter int NUM_SM   = 4,
    parameter int IRQ_BITS = 8,
    parameter int ADDR_W   = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_en,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [31:0]         data_in,
    input  logic                read_en,
    input  logic [ADDR_W-1:0]   read_addr,
    output logic [31:0]         data_out,
    output logic                read_valid,
    input  logic [NUM_SM-1:0]   tx_stall,
    input  logic [NUM_SM-1:0]   tx_over,
    input  logic [NUM_SM-1:0]   rx_under,
    input  logic [NUM_SM-1:0]   rx_stall,
    input  logic [NUM_SM-1:0]   rx_full,
    input  logic [NUM_SM-1:0]   rx_empty,
    input  logic [NUM_SM-1:0]   tx_full,
    input  logic [NUM_SM-1:0]   tx_empty,
    input  logic [IRQ_BITS-1:0] irq_set,
    input  logic [IRQ_BITS-1:0] irq_clr,
    output logic [NUM_SM-1:0]   sm_enable,
    output logic [NUM_SM-1:0]   sm_restart,
    output logic [NUM_SM-1:0]   clkdiv_restart,
    output logic [31:0]         input_sync_bypass,
    output logic [IRQ_BITS-1:0] irq_flags,
    output logic                irq_out
);

    typedef enum logic [1:0] {
        ALIAS_NORM = 2'b00,
        ALIAS_XOR  = 2'b01,
        ALIAS_SET  = 2'b10,
        ALIAS_CLR  = 2'b11
    } alias_e;

    localparam logic [11:0] OFF_CTRL      = 12'h000;
    localparam logic [11:0] OFF_FSTAT     = 12'h004;
    localparam logic [11:0] OFF_FDEBUG    = 12'h008;
    localparam logic [11:0] OFF_IRQ       = 12'h030;
    localparam logic [11:0] OFF_IRQ_FORCE = 12'h034;
    localparam logic [11:0] OFF_BYPASS    = 12'h038;
    localparam logic [11:0] OFF_INTE      = 12'h12C;
    localparam logic [11:0] OFF_INTF      = 12'h130;
    localparam logic [11:0] OFF_INTS      = 12'h134;

    function automatic logic [31:0] aliasWrite(input logic [31:0] cur,
                                               input logic [31:0] data,
                                               input alias_e      al);
        logic [31:0] result;
        case (al)
            ALIAS_NORM: result = data;
            ALIAS_XOR:  result = cur ^ data;
            ALIAS_SET:  result = cur | data;
            ALIAS_CLR:  result = cur & ~data;
            default:    result = cur;
        endcase
        return result;
    endfunction

    logic [NUM_SM-1:0]   r_smEnable;
    logic [NUM_SM-1:0]   r_smRestart;
    logic [NUM_SM-1:0]   r_clkdivRestart;
    logic [31:0]         r_bypass;
    logic [NUM_SM-1:0]   r_rxStall;
    logic [NUM_SM-1:0]   r_rxUnder;
    logic [NUM_SM-1:0]   r_txOver;
    logic [NUM_SM-1:0]   r_txStall;
    logic [IRQ_BITS-1:0] r_irq;
    logic [IRQ_BITS-1:0] r_inte;
    logic [IRQ_BITS-1:0] r_intf;
    logic [31:0]         r_dataOut;
    logic                r_readValid;
    logic                r_irqOut;

    logic [11:0]         w_wrOffset;
    logic [11:0]         w_rdOffset;
    alias_e              w_wrAlias;
    logic                w_wcAlias;
    logic                w_pulseAlias;
    logic                w_wrCtrl;
    logic                w_wrFdebug;
    logic                w_wrIrq;
    logic                w_wrIrqForce;
    logic                w_wrBypass;
    logic                w_wrInte;
    logic                w_wrIntf;
    logic                w_fdbgClr;
    logic [NUM_SM-1:0]   w_clrRxStall;
    logic [NUM_SM-1:0]   w_clrRxUnder;
    logic [NUM_SM-1:0]   w_clrTxOver;
    logic [NUM_SM-1:0]   w_clrTxStall;
    logic [IRQ_BITS-1:0] w_irqSet;
    logic [IRQ_BITS-1:0] w_irqClr;
    logic [IRQ_BITS-1:0] w_ints;
    logic [31:0]         w_rdData;
    logic                w_unusedAddr;

    assign w_wrOffset   = write_addr[11:0];
    assign w_rdOffset   = read_addr[11:0];
    assign w_wrAlias    = alias_e'(write_addr[13:12]);
    assign w_wcAlias    = (w_wrAlias == ALIAS_NORM) || (w_wrAlias == ALIAS_CLR);
    assign w_pulseAlias = (w_wrAlias != ALIAS_CLR);
    // Reads ignore the alias bits, so they only feed the write path.
    assign w_unusedAddr = ^{read_addr, write_addr};

    assign w_wrCtrl     = write_en && (w_wrOffset == OFF_CTRL);
    assign w_wrFdebug   = write_en && (w_wrOffset == OFF_FDEBUG);
    assign w_wrIrq      = write_en && (w_wrOffset == OFF_IRQ);
    assign w_wrIrqForce = write_en && (w_wrOffset == OFF_IRQ_FORCE);
    assign w_wrBypass   = write_en && (w_wrOffset == OFF_BYPASS);
    assign w_wrInte     = write_en && (w_wrOffset == OFF_INTE);
    assign w_wrIntf     = write_en && (w_wrOffset == OFF_INTF);

    assign w_fdbgClr    = w_wrFdebug && w_wcAlias;
    assign w_clrRxStall = {NUM_SM{w_fdbgClr}} & data_in[0+:NUM_SM];
    assign w_clrRxUnder = {NUM_SM{w_fdbgClr}} & data_in[8+:NUM_SM];
    assign w_clrTxOver  = {NUM_SM{w_fdbgClr}} & data_in[16+:NUM_SM];
    assign w_clrTxStall = {NUM_SM{w_fdbgClr}} & data_in[24+:NUM_SM];

    assign w_irqSet = irq_set
                    | ({IRQ_BITS{w_wrIrqForce && w_pulseAlias}} & data_in[IRQ_BITS-1:0]);
    assign w_irqClr = irq_clr
                    | ({IRQ_BITS{w_wrIrq && w_wcAlias}} & data_in[IRQ_BITS-1:0]);

    assign w_ints = (r_irq | r_intf) & r_inte;

    // Control and read/write registers; restart bits are self-clearing one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smEnable      <= '0;
            r_smRestart     <= '0;
            r_clkdivRestart <= '0;
            r_bypass        <= '0;
            r_inte          <= '0;
            r_intf          <= '0;
        end else begin
            if (w_wrCtrl)
                r_smEnable <= NUM_SM'(aliasWrite(32'(r_smEnable), data_in, w_wrAlias));
            r_smRestart     <= (w_wrCtrl && w_pulseAlias) ? data_in[4+:NUM_SM] : '0;
            r_clkdivRestart <= (w_wrCtrl && w_pulseAlias) ? data_in[8+:NUM_SM] : '0;
            if (w_wrBypass)
                r_bypass <= aliasWrite(r_bypass, data_in, w_wrAlias);
            if (w_wrInte)
                r_inte <= IRQ_BITS'(aliasWrite(32'(r_inte), data_in, w_wrAlias));
            if (w_wrIntf)
                r_intf <= IRQ_BITS'(aliasWrite(32'(r_intf), data_in, w_wrAlias));
        end
    end

    // Sticky bits: a hardware set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxStall <= '0;
            r_rxUnder <= '0;
            r_txOver  <= '0;
            r_txStall <= '0;
            r_irq     <= '0;
        end else begin
            r_rxStall <= (r_rxStall & ~w_clrRxStall) | rx_stall;
            r_rxUnder <= (r_rxUnder & ~w_clrRxUnder) | rx_under;
            r_txOver  <= (r_txOver  & ~w_clrTxOver)  | tx_over;
            r_txStall <= (r_txStall & ~w_clrTxStall) | tx_stall;
            r_irq     <= (r_irq     & ~w_irqClr)     | w_irqSet;
        end
    end

    always_comb begin
        w_rdData = '0;
        case (w_rdOffset)
            OFF_CTRL: w_rdData[0+:NUM_SM] = r_smEnable;
            OFF_FSTAT: begin
                w_rdData[0+:NUM_SM]  = rx_full;
                w_rdData[8+:NUM_SM]  = rx_empty;
                w_rdData[16+:NUM_SM] = tx_full;
                w_rdData[24+:NUM_SM] = tx_empty;
            end
            OFF_FDEBUG: begin
                w_rdData[0+:NUM_SM]  = r_rxStall;
                w_rdData[8+:NUM_SM]  = r_rxUnder;
                w_rdData[16+:NUM_SM] = r_txOver;
                w_rdData[24+:NUM_SM] = r_txStall;
            end
            OFF_IRQ:    w_rdData[0+:IRQ_BITS] = r_irq;
            OFF_BYPASS: w_rdData = r_bypass;
            OFF_INTE:   w_rdData[0+:IRQ_BITS] = r_inte;
            OFF_INTF:   w_rdData[0+:IRQ_BITS] = r_intf;
            OFF_INTS:   w_rdData[0+:IRQ_BITS] = w_ints;
            default:    w_rdData = '0;
        endcase
    end

    // Registered read port sees state from before any same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dataOut   <= '0;
            r_readValid <= 1'b0;
            r_irqOut    <= 1'b0;
        end else begin
            r_readValid <= read_en;
            if (read_en)
                r_dataOut <= w_rdData;
            r_irqOut <= |w_ints;
        end
    end

    assign data_out          = r_dataOut;
    assign read_valid        = r_readValid;
    assign sm_enable         = r_smEnable;
    assign sm_restart        = r_smRestart;
    assign clkdiv_restart    = r_clkdivRestart;
    assign input_sync_bypass = r_bypass;
    assign irq_flags         = r_irq;
    assign irq_out           = r_irqOut;

endmodule

// File: tb/tb_pio_ctrl_regs.sv
// Directed bench for pio_ctrl_regs: expected read data is queued when a read is
// issued and compared when read_valid comes back; outputs checked #1 after posedge.
module tb_pio_ctrl_regs;

    localparam int NUM_SM   = 4;
    localparam int IRQ_BITS = 8;
    localparam int ADDR_W   = 14;

    logic                clk = 1'b0;
    logic                rst;
    logic                write_en;
    logic [ADDR_W-1:0]   write_addr;
    logic [31:0]         data_in;
    logic                read_en;
    logic [ADDR_W-1:0]   read_addr;
    logic [31:0]         data_out;
    logic                read_valid;
    logic [NUM_SM-1:0]   tx_stall, tx_over, rx_under, rx_stall;
    logic [NUM_SM-1:0]   rx_full, rx_empty, tx_full, tx_empty;
    logic [IRQ_BITS-1:0] irq_set, irq_clr;
    logic [NUM_SM-1:0]   sm_enable, sm_restart, clkdiv_restart;
    logic [31:0]         input_sync_bypass;
    logic [IRQ_BITS-1:0] irq_flags;
    logic                irq_out;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];

    pio_ctrl_regs #(.NUM_SM(NUM_SM), .IRQ_BITS(IRQ_BITS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .write_en(write_en), .write_addr(write_addr), .data_in(data_in),
        .read_en(read_en), .read_addr(read_addr),
        .data_out(data_out), .read_valid(read_valid),
        .tx_stall(tx_stall), .tx_over(tx_over), .rx_under(rx_under), .rx_stall(rx_stall),
        .rx_full(rx_full), .rx_empty(rx_empty), .tx_full(tx_full), .tx_empty(tx_empty),
        .irq_set(irq_set), .irq_clr(irq_clr),
        .sm_enable(sm_enable), .sm_restart(sm_restart), .clkdiv_restart(clkdiv_restart),
        .input_sync_bypass(input_sync_bypass), .irq_flags(irq_flags), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic scoreboardCheck();
        logic        expValid;
        logic [31:0] expData;
        string       expTag;
        expValid = (expQ.size() != 0);
        checkOutput("read_valid", 32'(read_valid), 32'(expValid));
        if (expValid) begin
            expData = expQ.pop_front();
            expTag  = tagQ.pop_front();
            if (read_valid)
                checkOutput(expTag, data_out, expData);
        end
    endtask

    // One clock of stimulus; hardware pulses set by the caller are cleared afterwards.
    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa,
                                 input logic [31:0] wd, input logic re,
                                 input logic [ADDR_W-1:0] ra, input logic [31:0] expRead,
                                 input string tag);
        @(negedge clk);
        write_en   = we;
        write_addr = wa;
        data_in    = wd;
        read_en    = re;
        read_addr  = ra;
        if (re) begin
            expQ.push_back(expRead);
            tagQ.push_back(tag);
        end
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        tx_stall = '0;
        tx_over  = '0;
        rx_under = '0;
        rx_stall = '0;
        irq_set  = '0;
        irq_clr  = '0;
        scoreboardCheck();
    endtask

    task automatic writeReg(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 1'b0, '0, '0, "");
    endtask

    task automatic readReg(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string tag);
        applyStimulus(1'b0, '0, '0, 1'b1, a, e, tag);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, "");
    endtask

    initial begin
        rst = 1'b1;
        write_en = 1'b0; write_addr = '0; data_in = '0;
        read_en = 1'b0; read_addr = '0;
        tx_stall = '0; tx_over = '0; rx_under = '0; rx_stall = '0;
        rx_full = '0; rx_empty = '0; tx_full = '0; tx_empty = '0;
        irq_set = '0; irq_clr = '0;
        $display("[TB] start");

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_sm_enable", 32'(sm_enable), 32'h0);
        checkOutput("rst_sm_restart", 32'(sm_restart), 32'h0);
        checkOutput("rst_bypass", input_sync_bypass, 32'h0);
        checkOutput("rst_irq_flags", 32'(irq_flags), 32'h0);
        checkOutput("rst_data_out", data_out, 32'h0);
        checkOutput("rst_read_valid", 32'(read_valid), 32'h0);
        checkOutput("rst_irq_out", 32'(irq_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // CTRL: enables, restart pulses, alias behaviour of SC bits
        writeReg(14'h0000, 32'h0000_0F35);
        checkOutput("ctrl_sm_enable", 32'(sm_enable), 32'h5);
        checkOutput("ctrl_sm_restart", 32'(sm_restart), 32'h3);
        checkOutput("ctrl_clkdiv_restart", 32'(clkdiv_restart), 32'hF);
        idleCycle();
        checkOutput("ctrl_sm_restart_end", 32'(sm_restart), 32'h0);
        checkOutput("ctrl_clkdiv_restart_end", 32'(clkdiv_restart), 32'h0);
        readReg(14'h0000, 32'h0000_0005, "ctrl_read");
        writeReg(14'h3000, 32'h0000_0F31);
        checkOutput("ctrl_clr_sm_enable", 32'(sm_enable), 32'h4);
        checkOutput("ctrl_clr_no_pulse", 32'({sm_restart, clkdiv_restart}), 32'h0);
        writeReg(14'h1000, 32'h0000_0021);
        checkOutput("ctrl_xor_sm_enable", 32'(sm_enable), 32'h5);
        checkOutput("ctrl_xor_pulse", 32'(sm_restart), 32'h2);

        // INPUT_SYNC_BYPASS through SET/XOR/CLR aliases
        writeReg(14'h2038, 32'h0000_000F);
        readReg(14'h0038, 32'h0000_000F, "bypass_set");
        writeReg(14'h1038, 32'h0000_0005);
        readReg(14'h0038, 32'h0000_000A, "bypass_xor");
        writeReg(14'h3038, 32'h0000_0002);
        readReg(14'h2038, 32'h0000_0008, "bypass_clr_alias_read");
        checkOutput("bypass_port", input_sync_bypass, 32'h0000_0008);
        applyStimulus(1'b1, 14'h0038, 32'h0000_0055, 1'b1, 14'h0038, 32'h0000_0008, "bypass_rdw_old");
        readReg(14'h0038, 32'h0000_0055, "bypass_after_rdw");

        // FDEBUG sticky bits: set beats clear, SET alias keeps, CLR alias clears
        tx_over = 4'b0100;
        writeReg(14'h0008, 32'h0004_0000);
        readReg(14'h0008, 32'h0004_0000, "fdebug_set_priority");
        writeReg(14'h0008, 32'h0004_0000);
        readReg(14'h0008, 32'h0000_0000, "fdebug_cleared");
        rx_stall = 4'b0001;
        idleCycle();
        writeReg(14'h2008, 32'h0000_0001);
        writeReg(14'h1008, 32'h0000_0001);
        readReg(14'h0008, 32'h0000_0001, "fdebug_set_xor_keep");
        writeReg(14'h3008, 32'h0000_0001);
        readReg(14'h0008, 32'h0000_0000, "fdebug_clr_alias");

        // IRQ, INTE/INTF/INTS and irq_out latency
        writeReg(14'h012C, 32'h0000_0001);
        irq_set = 8'h01;
        idleCycle();
        checkOutput("irq_flags_set", 32'(irq_flags), 32'h01);
        checkOutput("irq_out_lag", 32'(irq_out), 32'h0);
        readReg(14'h0134, 32'h0000_0001, "ints_read");
        checkOutput("irq_out_high", 32'(irq_out), 32'h1);
        writeReg(14'h0030, 32'h0000_0001);
        checkOutput("irq_flags_cleared", 32'(irq_flags), 32'h00);
        checkOutput("irq_out_still_high", 32'(irq_out), 32'h1);
        idleCycle();
        checkOutput("irq_out_low", 32'(irq_out), 32'h0);
        irq_set = 8'h02;
        writeReg(14'h0030, 32'h0000_0002);
        checkOutput("irq_set_priority", 32'(irq_flags), 32'h02);
        irq_clr = 8'h02;
        idleCycle();
        checkOutput("irq_hw_clear", 32'(irq_flags), 32'h00);
        writeReg(14'h0034, 32'h0000_0080);
        checkOutput("irq_force", 32'(irq_flags), 32'h80);
        readReg(14'h0034, 32'h0000_0000, "irq_force_reads_zero");
        readReg(14'h0030, 32'h0000_0080, "irq_read");
        readReg(14'h0134, 32'h0000_0000, "ints_masked");
        writeReg(14'h0130, 32'h0000_0001);
        readReg(14'h0134, 32'h0000_0001, "ints_intf");

        // FSTAT live status, data_out hold, unmapped/RO accesses
        rx_empty = 4'hF;
        readReg(14'h0004, 32'h0000_0F00, "fstat_rx_empty");
        idleCycle();
        checkOutput("data_out_hold", data_out, 32'h0000_0F00);
        readReg(14'h00FC, 32'h0000_0000, "unmapped_read");
        writeReg(14'h00FC, 32'hFFFF_FFFF);
        writeReg(14'h0004, 32'hFFFF_FFFF);
        readReg(14'h0038, 32'h0000_0055, "bypass_after_unmapped_wr");
        readReg(14'h0004, 32'h0000_0F00, "fstat_after_ro_wr");

        // Reset in the middle of a restart pulse
        writeReg(14'h0000, 32'h0000_0F35);
        checkOutput("pre_rst_sm_restart", 32'(sm_restart), 32'h3);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_sm_restart", 32'(sm_restart), 32'h0);
        checkOutput("rst_async_clkdiv", 32'(clkdiv_restart), 32'h0);
        checkOutput("rst_async_sm_enable", 32'(sm_enable), 32'h0);
        checkOutput("rst_async_irq_out", 32'(irq_out), 32'h0);
        checkOutput("rst_async_irq_flags", 32'(irq_flags), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_no_pulse", 32'(sm_restart), 32'h0);
        checkOutput("post_rst_no_valid", 32'(read_valid), 32'h0);
        readReg(14'h0000, 32'h0000_0000, "post_rst_ctrl");
        readReg(14'h0038, 32'h0000_0000, "post_rst_bypass");
        readReg(14'h012C, 32'h0000_0000, "post_rst_inte");
        readReg(14'h0130, 32'h0000_0000, "post_rst_intf");
        readReg(14'h0008, 32'h0000_0000, "post_rst_fdebug");
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pio_ctrl_regs.md
PIO_CTRL_REGS -- requirements
Module: pio_ctrl_regs

Interface
REQ-001 SHALL have parameters, one per line: NUM_SM, default 4, number of state machines (legal 1..4); IRQ_BITS, default 8, width of the IRQ flag register (legal 1..8); ADDR_W, default 14, width of the byte address.
REQ-002 SHALL use one clock; reset is asynchronous and active-high, ports named clk and rst.
REQ-003 SHALL have ports, one per line:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- write_en  in  1  write strobe
- write_addr  in  ADDR_W  byte address of the write
- data_in  in  32  write data
- read_en  in  1  read strobe
- read_addr  in  ADDR_W  byte address of the read
- data_out  out  32  read data
- read_valid  out  1  data_out qualifier
- tx_stall, tx_over, rx_under, rx_stall  in  NUM_SM  hardware sticky-set pulses
- rx_full, rx_empty, tx_full, tx_empty  in  NUM_SM  live FIFO status
- irq_set, irq_clr  in  IRQ_BITS  hardware IRQ set/clear
- sm_enable  out  NUM_SM  state machine enables
- sm_restart, clkdiv_restart  out  NUM_SM  one-cycle pulses
- input_sync_bypass  out  32  sync bypass mask
- irq_flags  out  IRQ_BITS  current IRQ register
- irq_out  out  1  combined interrupt

Function
REQ-004 SHALL decode the register offset from addr[11:0] and the access alias from addr[13:12]: 00 normal, 01 XOR, 10 SET, 11 CLR.
REQ-005 SHALL implement the register map:
- 0x000 CTRL: [NUM_SM-1:0] SM_ENABLE (RW); [4+:NUM_SM] SM_RESTART (SC); [8+:NUM_SM] CLKDIV_RESTART (SC).
- 0x004 FSTAT (RO): rx_full[0+], rx_empty[8+], tx_full[16+], tx_empty[24+].
- 0x008 FDEBUG (WC): rx_stall[0+], rx_under[8+], tx_over[16+], tx_stall[24+].
- 0x030 IRQ (WC), bits [IRQ_BITS-1:0].
- 0x034 IRQ_FORCE (WO): a 1 sets the IRQ bit; reads as 0.
- 0x038 INPUT_SYNC_BYPASS (RW), 32 bits.
- 0x12C INTE (RW), bits [IRQ_BITS-1:0].
- 0x130 INTF (RW), bits [IRQ_BITS-1:0].
- 0x134 INTS (RO), computed as (IRQ | INTF) & INTE.
REQ-006 SHALL apply aliases to RW fields: normal writes the value, XOR gives reg^data, SET gives reg|data, CLR gives reg&~data; the register updates on the clk edge where write_en is high.
REQ-007 SHALL clear WC bits on a normal or CLR-alias write with the data bit at 1; XOR and SET aliases SHALL leave WC bits unchanged.
REQ-008 SHALL drive each SC bit as a pulse that is high exactly the one cycle after a normal, XOR or SET write with the data bit at 1; a CLR-alias write SHALL produce no pulse; the bit SHALL read as 0.
REQ-009 SHALL update each sticky bit as next = (cur & ~clr) | set, where set is the hardware pulse (plus irq_set|IRQ_FORCE for IRQ) and clr is the processor clear (plus irq_clr for IRQ).
REQ-010 SHALL give set priority: when a set and a clear hit the same bit in the same cycle, the bit ends at 1.
REQ-011 SHALL register reads with 1-cycle latency: data_out and read_valid update on the edge after read_en; read_valid is high exactly one cycle per read_en cycle.
REQ-012 SHALL return 0 for unmapped offsets, unimplemented bits, and WO/SC fields; alias addresses SHALL read the same as the base offset.
REQ-013 SHALL return the pre-write value when a read and a write to the same register occur in the same cycle.
REQ-014 SHALL register irq_out as |INTS, so it follows INTS with 1 cycle of delay.
REQ-015 SHALL hold data_out at its last value when read_en is low.
REQ-016 SHALL ignore writes to RO offsets and to unmapped offsets, with no side effects.

Reset
REQ-017 SHALL, while rst is high, force every register, data_out, read_valid, pulse output and irq_out to 0 asynchronously.
REQ-018 SHALL discard a read or write in flight when reset is asserted, with no pulse or read_valid after reset is released.
REQ-019 SHALL accept accesses from the first clk edge after rst is deasserted.

Verification
REQ-020 SHALL cover: normal write 0x0000_0F35 to 0x000 -> sm_enable=0x5; sm_restart=0x3 and clkdiv_restart=0xF for exactly one cycle; CTRL then reads 0x0000_0005.
REQ-021 SHALL cover: SET alias 0x2038 with data 0x0F, then XOR alias 0x1038 with data 0x05, then CLR alias 0x3038 with data 0x02 -> input_sync_bypass reads 0x0F, then 0x0A, then 0x08.
REQ-022 SHALL cover: tx_over[2] pulsed in the same cycle as a write of 0x0004_0000 to 0x008 -> FDEBUG bit 18 still set; a later write with no set pulse clears it.
REQ-023 SHALL cover: INTE=0x01, then irq_set[0] pulsed -> INTS=0x01 and irq_out=1 one cycle later; then write 0x01 to 0x030 -> irq_out=0 one cycle after the clear.
REQ-024 SHALL cover: read_en at 0x004 with rx_empty=0xF -> read_valid=1 with data_out=0x0000_0F00 on the next edge; a read of 0x0FC returns 0.
REQ-025 SHALL cover: rst asserted mid-pulse after a CTRL restart write -> sm_restart=0 immediately; sm_enable=0 and all reads return the reset values.
